// File: rtl/mp_mem_manager.sv
// Multi-port free-block manager: a circular FIFO of free block addresses with
// round-robin allocation and strobed release. Optional MEM_MGR_DOUBLE_FREE_CHK_EN adds a double-free bitmap.
module mp_mem_manager #(
  parameter int AWIDTH    = 10,
  parameter int NPORT     = 4,
  parameter int AF_MARGIN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORT-1:0]         ocp_req,
  output logic [NPORT-1:0]         ocp_rsp,
  output logic [NPORT-1:0]         ocp_vld,
  output logic [NPORT*AWIDTH-1:0]  ocp_block_addr,
  input  logic                     rls_vld,
  input  logic [AWIDTH-1:0]        rls_block_addr,
  output logic [AWIDTH:0]          emp_block_num,
  output logic                     full,
  output logic                     almost_full,
  output logic                     empty,
  output logic                     init_done,
  output logic                     rls_err
);

  localparam int DEPTH = 2**AWIDTH;
  localparam int PW    = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam logic [AWIDTH:0]   DEPTH_CNT = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0]   AF_CNT    = (AWIDTH+1)'(AF_MARGIN);
  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(DEPTH-1);
  localparam logic [PW:0]       NPORT_W   = (PW+1)'(NPORT);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t state, state_nxt;

  logic [AWIDTH-1:0] mem [DEPTH];
  logic [AWIDTH-1:0] rd_ptr, wr_ptr, init_cnt, head, wr_data;
  logic [AWIDTH:0]   count, count_nxt;
  logic [NPORT-1:0]  pending, new_req, grant;
  logic [PW-1:0]     rr_ptr, gnt_idx, off;
  logic [PW:0]       sum;
  logic [2*NPORT-1:0] rot_full;
  logic [NPORT-1:0]  rot;
  logic init_wr, run_en, push, pop, rls_ok, rls_bad;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:  if (init_cnt == LAST_ADDR) state_nxt = S_RUN;
      S_RUN:   state_nxt = S_RUN;
      default: state_nxt = S_INIT;
    endcase
  end

  always_comb begin
    init_wr = (state == S_INIT);
    run_en  = (state == S_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      init_cnt  <= '0;
      init_done <= 1'b0;
    end else if (init_wr) begin
      init_cnt <= init_cnt + 1'b1;
      if (init_cnt == LAST_ADDR) init_done <= 1'b1;
    end
  end

  // Rotate pending so the search starts at rr_ptr; lowest set bit wins.
  always_comb begin
    rot_full = {pending, pending} >> rr_ptr;
    rot      = rot_full[NPORT-1:0];
    off      = '0;
    for (int k = NPORT-1; k >= 0; k--) begin
      if (rot[k]) off = PW'(k);
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= NPORT_W) sum = sum - NPORT_W;
    gnt_idx = sum[PW-1:0];
    grant   = '0;
    if (run_en && count != '0 && rot != '0) grant = NPORT'(1) << gnt_idx;
  end

  assign head    = mem[rd_ptr];
  assign pop     = |grant;
  assign new_req = ocp_req & ~pending;

`ifdef MEM_MGR_DOUBLE_FREE_CHK_EN
  logic [DEPTH-1:0] alloc_map;

  assign rls_ok = run_en && rls_vld && (count != DEPTH_CNT) && alloc_map[rls_block_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alloc_map <= '0;
    end else begin
      if (pop)    alloc_map[head]           <= 1'b1;
      if (rls_ok) alloc_map[rls_block_addr] <= 1'b0;
    end
  end
`else
  assign rls_ok = run_en && rls_vld && (count != DEPTH_CNT);
`endif

  assign rls_bad = run_en && rls_vld && !rls_ok;
  assign push    = init_wr | rls_ok;
  assign wr_data = init_wr ? init_cnt : rls_block_addr;

  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + 1'b1;
    else if (pop && !push) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      pending        <= '0;
      rr_ptr         <= '0;
      ocp_rsp        <= '0;
      ocp_vld        <= '0;
      ocp_block_addr <= '0;
      rls_err        <= 1'b0;
      emp_block_num  <= '0;
      empty          <= 1'b1;
      full           <= 1'b0;
      almost_full    <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        rr_ptr <= (gnt_idx == PW'(NPORT-1)) ? '0 : gnt_idx + 1'b1;
      end
      count   <= count_nxt;
      pending <= (pending & ~grant) | new_req;
      ocp_rsp <= new_req;
      ocp_vld <= grant;
      for (int i = 0; i < NPORT; i++) begin
        if (grant[i]) ocp_block_addr[i*AWIDTH +: AWIDTH] <= head;
      end
      if (rls_bad) rls_err <= 1'b1;
      emp_block_num <= count_nxt;
      empty         <= (count_nxt == '0);
      full          <= (count_nxt == DEPTH_CNT);
      almost_full   <= (count_nxt <= AF_CNT);
    end
  end

endmodule

// File: tb/tb_mp_mem_manager.sv
// Self-checking bench for mp_mem_manager: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based free-list model.
module tb_mp_mem_manager;

  localparam int AW    = 4;
  localparam int NP    = 4;
  localparam int AFM   = 4;
  localparam int DEPTH = 16;
`ifdef MEM_MGR_DOUBLE_FREE_CHK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP-1:0]     ocp_req = '0;
  logic [NP-1:0]     ocp_rsp, ocp_vld;
  logic [NP*AW-1:0]  ocp_block_addr;
  logic              rls_vld = 1'b0;
  logic [AW-1:0]     rls_block_addr = '0;
  logic [AW:0]       emp_block_num;
  logic              full, almost_full, empty, init_done, rls_err;

  mp_mem_manager #(.AWIDTH(AW), .NPORT(NP), .AF_MARGIN(AFM)) dut (
    .clk(clk), .rst(rst),
    .ocp_req(ocp_req), .ocp_rsp(ocp_rsp), .ocp_vld(ocp_vld),
    .ocp_block_addr(ocp_block_addr),
    .rls_vld(rls_vld), .rls_block_addr(rls_block_addr),
    .emp_block_num(emp_block_num), .full(full), .almost_full(almost_full),
    .empty(empty), .init_done(init_done), .rls_err(rls_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the free list is a plain queue of addresses.
  int          q_free[$];
  bit [NP-1:0] m_pend;
  int          m_rr;
  int          m_init_idx;
  bit          m_init_done;
  bit          m_alloc[DEPTH];
  bit          m_err;
  bit [NP-1:0] e_rsp, e_vld;
  bit [AW-1:0] e_addr[NP];

  typedef struct {
    logic [NP-1:0] req;
    logic          rv;
    logic [AW-1:0] ra;
    logic [NP-1:0] x_rsp;
    logic [NP-1:0] x_vld;
    logic [AW:0]   x_cnt;
    logic [AW-1:0] x_addr;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] slot(input int p);
    logic [NP*AW-1:0] t;
    t = ocp_block_addr >> (p*AW);
    return t[AW-1:0];
  endfunction

  function automatic void modelReset();
    q_free.delete();
    m_pend = '0;
    m_rr = 0;
    m_init_idx = 0;
    m_init_done = 1'b0;
    foreach (m_alloc[i]) m_alloc[i] = 1'b0;
    m_err = 1'b0;
    e_rsp = '0;
    e_vld = '0;
    foreach (e_addr[i]) e_addr[i] = '0;
  endfunction

  function automatic void modelStep(input logic [NP-1:0] req, input logic rv, input logic [AW-1:0] ra);
    int sz0;
    int p;
    bit [NP-1:0] fresh;
    bit rel_ok;
    bit found;
    sz0    = q_free.size();
    fresh  = req & ~m_pend;
    e_rsp  = fresh;
    e_vld  = '0;
    rel_ok = 1'b0;
    found  = 1'b0;
    if (!m_init_done) begin
      q_free.push_back(m_init_idx);
      m_init_idx++;
      if (m_init_idx == DEPTH) m_init_done = 1'b1;
    end else begin
      if (rv) begin
        rel_ok = (sz0 < DEPTH) && (!CHK || m_alloc[ra]);
        if (!rel_ok) m_err = 1'b1;
      end
      if (sz0 > 0) begin
        for (int k = 0; k < NP; k++) begin
          p = (m_rr + k) % NP;
          if (!found && m_pend[p]) begin
            found = 1'b1;
            e_addr[p] = AW'(q_free.pop_front());
            e_vld[p] = 1'b1;
            m_pend[p] = 1'b0;
            m_alloc[e_addr[p]] = 1'b1;
            m_rr = (p + 1) % NP;
          end
        end
      end
      if (rel_ok) begin
        q_free.push_back(int'(ra));
        m_alloc[ra] = 1'b0;
      end
    end
    m_pend = m_pend | fresh;
  endfunction

  task automatic checkOutput();
    int sz;
    sz = q_free.size();
    chk("rsp", 32'(ocp_rsp), 32'(e_rsp));
    chk("vld", 32'(ocp_vld), 32'(e_vld));
    for (int p = 0; p < NP; p++) chk($sformatf("addr%0d", p), 32'(slot(p)), 32'(e_addr[p]));
    chk("count", 32'(emp_block_num), 32'(sz));
    chk("empty", 32'(empty), 32'(sz == 0));
    chk("full", 32'(full), 32'(sz == DEPTH));
    chk("almost_full", 32'(almost_full), 32'(sz <= AFM));
    chk("init_done", 32'(init_done), 32'(m_init_done));
    chk("rls_err", 32'(rls_err), 32'(m_err));
  endtask

  task automatic applyStimulus(input logic [NP-1:0] req, input logic rv, input logic [AW-1:0] ra);
    ocp_req = req;
    rls_vld = rv;
    rls_block_addr = ra;
    modelStep(req, rv, ra);
    @(posedge clk);
    #1;
    checkOutput();
    ocp_req = '0;
    rls_vld = 1'b0;
  endtask

  task automatic doReset();
    rst = 1'b1;
    ocp_req = '0;
    rls_vld = 1'b0;
    modelReset();
    @(posedge clk);
    #1;
    checkOutput();
    rst = 1'b0;
  endtask

  task automatic initRun();
    repeat (DEPTH) applyStimulus('0, 1'b0, '0);
  endtask

  function automatic logic [AW-1:0] pickRelease();
    int cand[$];
    foreach (m_alloc[i]) if (m_alloc[i]) cand.push_back(i);
    if (cand.size() > 0 && $urandom_range(0, 99) < 85)
      return AW'(cand[$urandom_range(0, cand.size()-1)]);
    return AW'($urandom_range(0, DEPTH-1));
  endfunction

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [NP-1:0] vld_seen;

    tbl[0] = '{4'b1111, 1'b0, 4'h0, 4'b1111, 4'b0000, 5'd16, 4'h0};
    tbl[1] = '{4'b0000, 1'b0, 4'h0, 4'b0000, 4'b0001, 5'd15, 4'h0};
    tbl[2] = '{4'b0000, 1'b0, 4'h0, 4'b0000, 4'b0010, 5'd14, 4'h1};
    tbl[3] = '{4'b0000, 1'b0, 4'h0, 4'b0000, 4'b0100, 5'd13, 4'h2};
    tbl[4] = '{4'b0000, 1'b0, 4'h0, 4'b0000, 4'b1000, 5'd12, 4'h3};
    tbl[5] = '{4'b0001, 1'b0, 4'h0, 4'b0001, 4'b0000, 5'd12, 4'h0};
    tbl[6] = '{4'b0000, 1'b1, 4'h2, 4'b0000, 4'b0001, 5'd12, 4'h4};
    tbl[7] = '{4'b0000, 1'b1, 4'h1, 4'b0000, 4'b0000, 5'd13, 4'h0};

    $display("[TB] reset and init");
    doReset();
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_almost_full", 32'(almost_full), 32'd1);
    chk("reset_count", 32'(emp_block_num), 32'd0);
    repeat (DEPTH-1) applyStimulus('0, 1'b0, '0);
    chk("init_done_early", 32'(init_done), 32'd0);
    applyStimulus('0, 1'b0, '0);
    chk("init_done_16", 32'(init_done), 32'd1);
    chk("init_full", 32'(full), 32'd1);
    chk("init_count", 32'(emp_block_num), 32'd16);

    $display("[TB] vector table");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(tbl[i].req, tbl[i].rv, tbl[i].ra);
      chk($sformatf("tbl%0d_rsp", i), 32'(ocp_rsp), 32'(tbl[i].x_rsp));
      chk($sformatf("tbl%0d_vld", i), 32'(ocp_vld), 32'(tbl[i].x_vld));
      chk($sformatf("tbl%0d_cnt", i), 32'(emp_block_num), 32'(tbl[i].x_cnt));
      for (int p = 0; p < NP; p++)
        if (tbl[i].x_vld[p]) chk($sformatf("tbl%0d_addr", i), 32'(slot(p)), 32'(tbl[i].x_addr));
    end

    $display("[TB] exhaust pool, pend, release 0x7");
    doReset();
    initRun();
    for (int n = 0; n < DEPTH; n++) begin
      applyStimulus(4'b0010, 1'b0, '0);
      applyStimulus('0, 1'b0, '0);
      chk("drain_vld", 32'(ocp_vld), 32'b0010);
      chk("drain_addr", 32'(slot(1)), 32'(n));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    applyStimulus(4'b0010, 1'b0, '0);
    chk("pend_rsp", 32'(ocp_rsp), 32'b0010);
    repeat (3) begin
      applyStimulus('0, 1'b0, '0);
      chk("pend_wait_vld", 32'(ocp_vld), 32'd0);
    end
    applyStimulus('0, 1'b1, 4'h7);
    chk("rls_no_bypass_vld", 32'(ocp_vld), 32'd0);
    chk("rls_count", 32'(emp_block_num), 32'd1);
    applyStimulus('0, 1'b0, '0);
    chk("rls_served_vld", 32'(ocp_vld), 32'b0010);
    chk("rls_served_addr", 32'(slot(1)), 32'h7);

    $display("[TB] grant and release in the same cycle");
    applyStimulus('0, 1'b1, 4'h3);
    applyStimulus(4'b0100, 1'b0, '0);
    applyStimulus('0, 1'b1, 4'h4);
    chk("same_cycle_vld", 32'(ocp_vld), 32'b0100);
    chk("same_cycle_addr", 32'(slot(2)), 32'h3);
    chk("same_cycle_count", 32'(emp_block_num), 32'd1);

    $display("[TB] release while full and double release");
    doReset();
    initRun();
    applyStimulus('0, 1'b1, 4'h5);
    chk("full_rls_err", 32'(rls_err), 32'd1);
    chk("full_rls_count", 32'(emp_block_num), 32'd16);
    doReset();
    initRun();
    repeat (6) begin
      applyStimulus(4'b0001, 1'b0, '0);
      applyStimulus('0, 1'b0, '0);
    end
    applyStimulus('0, 1'b1, 4'h5);
    chk("rls5_first_count", 32'(emp_block_num), 32'd11);
    chk("rls5_first_err", 32'(rls_err), 32'd0);
    applyStimulus('0, 1'b1, 4'h5);
`ifdef MEM_MGR_DOUBLE_FREE_CHK_EN
    chk("rls5_second_count", 32'(emp_block_num), 32'd11);
    chk("rls5_second_err", 32'(rls_err), 32'd1);
`else
    chk("rls5_second_count", 32'(emp_block_num), 32'd12);
    chk("rls5_second_err", 32'(rls_err), 32'd0);
`endif

    $display("[TB] reset with pending requests");
    doReset();
    initRun();
    repeat (DEPTH) begin
      applyStimulus(4'b0001, 1'b0, '0);
      applyStimulus('0, 1'b0, '0);
    end
    applyStimulus(4'b0111, 1'b0, '0);
    chk("pend3_rsp", 32'(ocp_rsp), 32'b0111);
    applyStimulus('0, 1'b0, '0);
    doReset();
    vld_seen = '0;
    repeat (DEPTH + 5) begin
      applyStimulus('0, 1'b0, '0);
      vld_seen = vld_seen | ocp_vld;
    end
    chk("post_reset_no_vld", 32'(vld_seen), 32'd0);
    chk("post_reset_init_done", 32'(init_done), 32'd1);
    chk("post_reset_count", 32'(emp_block_num), 32'd16);
    applyStimulus(4'b0001, 1'b0, '0);
    applyStimulus('0, 1'b0, '0);
    chk("rerequest_vld", 32'(ocp_vld), 32'b0001);
    chk("rerequest_addr", 32'(slot(0)), 32'h0);

    $display("[TB] randomized traffic, release-light");
    doReset();
    initRun();
    for (int c = 0; c < 300; c++) begin
      if (c == 150) doReset();
      applyStimulus(NP'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0), pickRelease());
    end
    $display("[TB] randomized traffic, release-heavy");
    for (int c = 0; c < 300; c++) begin
      applyStimulus(NP'($urandom_range(0, 15) & $urandom_range(0, 15)),
                    ($urandom_range(0, 3) != 0), pickRelease());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mp_mem_manager.md
MP_MEM_MANAGER -- requirements
Module: mp_mem_manager

Interface
REQ-001 SHALL have parameter AWIDTH, default 10, block address width; DEPTH = 2**AWIDTH blocks.
REQ-002 SHALL have parameter NPORT, default 4, number of allocation request ports (1..8).
REQ-003 SHALL have parameter AF_MARGIN, default 4, almost_full asserts when free count <= AF_MARGIN.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port ocp_req  input  NPORT  per-port one-cycle allocation request pulse.
REQ-007 SHALL have port ocp_rsp  output  NPORT  per-port request-accepted pulse.
REQ-008 SHALL have port ocp_vld  output  NPORT  per-port address-delivered pulse.
REQ-009 SHALL have port ocp_block_addr  output  NPORT*AWIDTH  per-port allocated address, slice i = [i*AWIDTH +: AWIDTH].
REQ-010 SHALL have port rls_vld  input  1  release strobe.
REQ-011 SHALL have port rls_block_addr  input  AWIDTH  block being released.
REQ-012 SHALL have port emp_block_num  output  AWIDTH+1  current free-block count.
REQ-013 SHALL have ports full, almost_full, empty  output  1 each  free-list status.
REQ-014 SHALL have port init_done  output  1  free list initialised.
REQ-015 SHALL have port rls_err  output  1  sticky illegal-release flag.

Function
REQ-016 SHALL store free block addresses in a circular FIFO of DEPTH entries (read/write pointers, AWIDTH+1-bit count).
REQ-017 SHALL run FSM INIT -> RUN; INIT writes addresses 0..DEPTH-1, one per cycle, then sets init_done and enters RUN (DEPTH cycles after reset release).
REQ-018 SHALL sample ocp_req[i] at each edge into pending[i]; a request on a port already pending SHALL be ignored.
REQ-019 SHALL assert ocp_rsp[i] for one cycle in the cycle after a request is newly captured into pending[i], including during INIT.
REQ-020 SHALL, in RUN with count>0, grant exactly one pending port per cycle by round-robin, starting search at the port after the last granted (port 0 after reset).
REQ-021 SHALL, on grant, pop FIFO head, drive it on slice i, pulse ocp_vld[i] for one cycle, clear pending[i]; minimum req-to-vld latency 2 cycles.
REQ-022 SHALL hold ocp_block_addr slice i stable until the next grant to port i.
REQ-023 SHALL, in RUN, push rls_block_addr on rls_vld when count<DEPTH; release with count==DEPTH SHALL be dropped and set rls_err.
REQ-024 SHALL ignore rls_vld while in INIT.
REQ-025 SHALL, on same-cycle grant and release, perform both; count unchanged.
REQ-026 SHALL NOT bypass a released block to a grant in the same cycle; when empty, pending requests wait and are served the cycle after a release is written.
REQ-027 SHALL drive empty = (count==0), full = (count==DEPTH), almost_full = (count<=AF_MARGIN), emp_block_num = count, all registered.

Reset
REQ-028 SHALL on rst clear pointers, count, pending, round-robin pointer, rls_err, init_done, ocp_rsp, ocp_vld, ocp_block_addr to 0; FSM to INIT.
REQ-029 SHALL reset outputs: empty=1, full=0, almost_full=1, emp_block_num=0.
REQ-030 SHALL on rst asserted mid-operation discard all pending requests and allocations and re-run INIT after release.

Configuration
REQ-031 SHALL with macro MEM_MGR_DOUBLE_FREE_CHK_EN defined keep a DEPTH-bit allocated bitmap (set on grant, cleared on release); release of a non-allocated block SHALL be dropped and set rls_err.
REQ-032 SHALL without MEM_MGR_DOUBLE_FREE_CHK_EN omit the bitmap and accept any release when count<DEPTH.

Verification (AWIDTH=4, NPORT=4, AF_MARGIN=4)
REQ-033 SHALL check: rst release -> init_done after 16 cycles, full=1, emp_block_num=16.
REQ-034 SHALL check: ocp_req=4'b1111 one cycle -> ocp_rsp=4'b1111 next cycle; ocp_vld ports 0,1,2,3 on consecutive cycles with addresses 0,1,2,3.
REQ-035 SHALL check: 16 single-port requests -> empty=1; 17th request pends; rls of 0x7 -> that port gets 0x7 two cycles later.
REQ-036 SHALL check: grant plus rls of an allocated block same cycle -> emp_block_num unchanged.
REQ-037 SHALL check: with MEM_MGR_DOUBLE_FREE_CHK_EN, releasing 0x5 twice -> second dropped, rls_err=1; release when full -> rls_err=1, count stays 16.
REQ-038 SHALL check: rst pulsed with 3 pending requests -> no ocp_vld after release until re-requested, init re-runs.
